// File: rtl/seq_pkg.sv
// Shared sequencer constants for the am2910 interrupt injector.
package seq_pkg;

    localparam int unsigned ADDR_W = 4;

    localparam logic [3:0] CJS  = 4'h1;
    localparam logic [3:0] CRTN = 4'hA;
    localparam logic [3:0] CONT = 4'hE;

    localparam logic [ADDR_W-1:0] VEC_BASE_DEF = 4'h8;

endpackage

// File: rtl/seq_prio_enc.sv
// Lowest-index-first priority encoder: valid flag plus index of the lowest set bit.
module seq_prio_enc #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last write.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/seq_irq_injector.sv
// Interrupt injector in front of the am2910: forces a CJS to a vector on safe CONT words.
// Optional nested preemption is enabled by defining SEQ_IRQ_NEST_EN.
module seq_irq_injector
    import seq_pkg::*;
#(
    parameter int unsigned       N_IRQ    = 4,
    parameter logic [ADDR_W-1:0] VEC_BASE = VEC_BASE_DEF
) (
    input  logic                                     CP,
    input  logic                                     RESET_N,
    input  logic [N_IRQ-1:0]                         IRQ,
    input  logic [N_IRQ-1:0]                         IRQ_MASK,
    input  logic                                     INT_EN,
    input  logic                                     EOI,
    input  logic [3:0]                               PL_I,
    input  logic [ADDR_W-1:0]                        PL_D,
    input  logic                                     PL_CC,
    input  logic                                     PL_CCEN,
    input  logic                                     PL_RLD,
    input  logic                                     PL_INT_OK,
    input  logic                                     SEQ_FULL,
    output logic [3:0]                               I_OUT,
    output logic [ADDR_W-1:0]                        D_OUT,
    output logic                                     CC_OUT,
    output logic                                     CCEN_OUT,
    output logic                                     RLD_OUT,
    output logic                                     ACK,
    output logic [((N_IRQ > 1) ? $clog2(N_IRQ) : 1)-1:0] ACK_ID,
    output logic [N_IRQ-1:0]                         IN_SERVICE
);

    localparam int unsigned ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    logic [N_IRQ-1:0] irq_q;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] eligible;
    logic             sel_valid;
    logic [ID_W-1:0]  sel;
    logic             isr_valid;
    logic [ID_W-1:0]  isr_idx;
    logic             nest_ok;
    logic             inject;
    logic [N_IRQ-1:0] inj_mask;
    logic [N_IRQ-1:0] eoi_mask;

    assign rise     = IRQ & ~irq_q;
    assign eligible = pending & ~IRQ_MASK;

    seq_prio_enc #(.N(N_IRQ), .IDX_W(ID_W)) u_pend_enc (
        .req   (eligible),
        .valid (sel_valid),
        .idx   (sel)
    );

    seq_prio_enc #(.N(N_IRQ), .IDX_W(ID_W)) u_isr_enc (
        .req   (IN_SERVICE),
        .valid (isr_valid),
        .idx   (isr_idx)
    );

`ifdef SEQ_IRQ_NEST_EN
    // Preempt only with strictly higher priority than the innermost active level.
    assign nest_ok = !isr_valid || (sel < isr_idx);
`else
    assign nest_ok = !isr_valid;
`endif

    // CONT-only injection guarantees no microprogram branch is dropped.
    assign inject = INT_EN && sel_valid && (PL_I == CONT) && PL_INT_OK && SEQ_FULL && nest_ok;

    always_comb begin
        inj_mask = '0;
        eoi_mask = '0;
        if (inject)             inj_mask = N_IRQ'(1) << sel;
        if (EOI && isr_valid)   eoi_mask = N_IRQ'(1) << isr_idx;
    end

    // Zero-latency output mux toward the sequencer.
    always_comb begin
        I_OUT    = PL_I;
        D_OUT    = PL_D;
        CC_OUT   = PL_CC;
        CCEN_OUT = PL_CCEN;
        RLD_OUT  = PL_RLD;
        if (inject) begin
            I_OUT    = CJS;
            D_OUT    = VEC_BASE + ADDR_W'(sel);
            CC_OUT   = 1'b0;
            CCEN_OUT = 1'b0;
            RLD_OUT  = 1'b1;
        end
    end

    // A fresh edge on the injected line re-arms its pending bit.
    always_ff @(posedge CP or negedge RESET_N) begin
        if (!RESET_N) begin
            irq_q      <= '0;
            pending    <= '0;
            IN_SERVICE <= '0;
            ACK        <= 1'b0;
            ACK_ID     <= '0;
        end else begin
            irq_q      <= IRQ;
            pending    <= (pending & ~inj_mask) | rise;
            IN_SERVICE <= (IN_SERVICE & ~eoi_mask) | inj_mask;
            ACK        <= inject;
            if (inject) ACK_ID <= sel;
        end
    end

endmodule
